// File: rtl/fg_prog_sequencer.sv
// Programming sequencer for a floating-gate island: latches one program command,
// drives the row/column decoders and prog enables, times the injection pulses, then releases.
module fg_prog_sequencer #(
    parameter int unsigned ROW_BITS      = 6,
    parameter int unsigned COL_BITS      = 6,
    parameter int unsigned PW_BITS       = 16,
    parameter int unsigned NP_BITS       = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [PW_BITS-1:0]  cmd_pulse_width,
    input  logic [NP_BITS-1:0]  cmd_num_pulses,
    input  logic                abort,
    output logic [ROW_BITS-1:0] dec_v_addr,
    output logic                dec_v_en,
    output logic [COL_BITS-1:0] dec_h_addr,
    output logic                dec_h_en,
    output logic                prog_mode,
    output logic                vinj_pulse,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [NP_BITS-1:0]  pulses_done
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CW = (PW_BITS > SW) ? PW_BITS : SW;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NP_BITS-1:0]  pulses_q, pulses_d;
    logic                aborted_q, aborted_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [PW_BITS-1:0]  pw_q, pw_d;
    logic [NP_BITS-1:0]  np_q, np_d;
    logic [CW-1:0]       pw_ld;
    logic                active;
    logic                in_prog;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pulses_q  <= '0;
            aborted_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            pw_q      <= '0;
            np_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulses_q  <= pulses_d;
            aborted_q <= aborted_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pw_q      <= pw_d;
            np_q      <= np_d;
        end
    end

    // Counter holds remaining cycles minus one; a zero width still gives a one-cycle pulse.
    always_comb begin
        pw_ld = (pw_q == '0) ? '0 : CW'(pw_q - PW_BITS'(1));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulses_d  = pulses_q;
        aborted_d = aborted_q;
        row_d     = row_q;
        col_d     = col_q;
        pw_d      = pw_q;
        np_d      = np_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    row_d     = cmd_row;
                    col_d     = cmd_col;
                    pw_d      = cmd_pulse_width;
                    np_d      = cmd_num_pulses;
                    pulses_d  = '0;
                    aborted_d = 1'b0;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_RELEASE;
                end else if (cnt_q == '0) begin
                    if (np_q == '0) begin
                        cnt_d   = SETTLE_LD;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d   = pw_ld;
                        state_d = ST_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_RELEASE;
                end else if (cnt_q == '0) begin
                    pulses_d = pulses_q + NP_BITS'(1);
                    cnt_d    = SETTLE_LD;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_RELEASE;
                end else if (cnt_q == '0) begin
                    if (pulses_q < np_q) begin
                        cnt_d   = pw_ld;
                        state_d = ST_PULSE;
                    end else begin
                        cnt_d   = SETTLE_LD;
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        active      = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GAP);
        in_prog     = active || (state_q == ST_RELEASE);
        cmd_ready   = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        dec_v_en    = active;
        dec_h_en    = active;
        prog_mode   = in_prog;
        vinj_pulse  = (state_q == ST_PULSE);
        dec_v_addr  = in_prog ? row_q : '0;
        dec_h_addr  = in_prog ? col_q : '0;
        aborted     = aborted_q;
        pulses_done = pulses_q;
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: directed command table, mid-pulse reset, and randomized
// commands, all checked cycle by cycle against a timeline model of the command.
module tb_fg_prog_sequencer;

    localparam int S  = 4;
    localparam int RB = 6;
    localparam int CB = 6;
    localparam int PB = 16;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [RB-1:0] cmd_row = '0;
    logic [CB-1:0] cmd_col = '0;
    logic [PB-1:0] cmd_pulse_width = '0;
    logic [NB-1:0] cmd_num_pulses = '0;
    logic          abort = 1'b0;
    logic [RB-1:0] dec_v_addr;
    logic          dec_v_en;
    logic [CB-1:0] dec_h_addr;
    logic          dec_h_en;
    logic          prog_mode;
    logic          vinj_pulse;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [NB-1:0] pulses_done;

    fg_prog_sequencer #(
        .ROW_BITS(RB), .COL_BITS(CB), .PW_BITS(PB), .NP_BITS(NB), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulse_width(cmd_pulse_width),
        .cmd_num_pulses(cmd_num_pulses), .abort(abort),
        .dec_v_addr(dec_v_addr), .dec_v_en(dec_v_en), .dec_h_addr(dec_h_addr),
        .dec_h_en(dec_h_en), .prog_mode(prog_mode), .vinj_pulse(vinj_pulse),
        .busy(busy), .done(done), .aborted(aborted), .pulses_done(pulses_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int ready, vaddr, ven, haddr, hen, prog, vinj, busy, done, ab, pd;
    } exp_t;

    typedef struct {
        int row, col, w, n, a;
        bit hold;
        int exp_done, exp_pd, exp_ab;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, k, act, exp);
        end
    endtask

    // Expected outputs k cycles after the accept edge, derived from the command timeline:
    // S setup cycles, N x (W pulse + S gap), S release cycles, one done cycle.
    function automatic exp_t model(int k, int row, int col, int w, int n, int a);
        exp_t e;
        int we, p, end_act, t_done, lim, j, cnt;
        e       = '{default: 0};
        we      = (w == 0) ? 1 : w;
        p       = we + S;
        end_act = (a != 0) ? a : S + n * p;
        t_done  = end_act + S + 1;
        lim     = (k < end_act) ? k : end_act;
        if (lim >= S + we + 1) begin
            cnt  = (lim - S - we - 1) / p + 1;
            e.pd = (cnt < n) ? cnt : n;
        end
        e.ab = (a != 0 && k > a) ? 1 : 0;
        if (k <= end_act) begin
            e.busy = 1; e.ven = 1; e.hen = 1; e.prog = 1;
            e.vaddr = row; e.haddr = col;
            if (k > S) begin
                j = k - S - 1;
                if ((j / p) < n && (j % p) < we) e.vinj = 1;
            end
        end else if (k < t_done) begin
            e.busy = 1; e.prog = 1; e.vaddr = row; e.haddr = col;
        end else if (k == t_done) begin
            e.busy = 1; e.done = 1;
        end else begin
            e.ready = 1;
        end
        return e;
    endfunction

    task automatic chk_out(input int k, input exp_t e);
        chk("cmd_ready",   k, cmd_ready,   e.ready);
        chk("dec_v_addr",  k, dec_v_addr,  e.vaddr);
        chk("dec_v_en",    k, dec_v_en,    e.ven);
        chk("dec_h_addr",  k, dec_h_addr,  e.haddr);
        chk("dec_h_en",    k, dec_h_en,    e.hen);
        chk("prog_mode",   k, prog_mode,   e.prog);
        chk("vinj_pulse",  k, vinj_pulse,  e.vinj);
        chk("busy",        k, busy,        e.busy);
        chk("done",        k, done,        e.done);
        chk("aborted",     k, aborted,     e.ab);
        chk("pulses_done", k, pulses_done, e.pd);
        if (vinj_pulse === 1'b1)
            chk("vinj_needs_enables", k, {31'd0, dec_v_en & dec_h_en & prog_mode}, 1);
    endtask

    // Starts at a falling edge in an idle cycle (cycle 0) and returns at the falling edge
    // of the idle cycle after done, so consecutive calls run back to back.
    task automatic run_cmd(input int row, input int col, input int w, input int n, input int a,
                           input bit hold, input bit noise,
                           output int done_at, output int pd_last, output int ab_last);
        int we, end_act, t_done;
        exp_t e;
        we      = (w == 0) ? 1 : w;
        end_act = (a != 0) ? a : S + n * (we + S);
        t_done  = end_act + S + 1;
        chk("cmd_ready_at_accept", 0, cmd_ready, 1);
        cmd_valid       = 1'b1;
        cmd_row         = RB'(row);
        cmd_col         = CB'(col);
        cmd_pulse_width = PB'(w);
        cmd_num_pulses  = NB'(n);
        abort           = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        done_at = -1;
        pd_last = -1;
        ab_last = -1;
        for (int k = 1; k <= t_done + 1; k++) begin
            @(negedge clk);
            e = model(k, row, col, w, n, a);
            chk_out(k, e);
            if (done === 1'b1 && done_at < 0) done_at = k;
            pd_last         = int'(pulses_done);
            ab_last         = int'(aborted);
            cmd_valid       = hold;
            cmd_row         = RB'($urandom);
            cmd_col         = CB'($urandom);
            cmd_pulse_width = PB'($urandom);
            cmd_num_pulses  = NB'($urandom);
            if (k == a) abort = 1'b1;
            else if (noise && k > end_act) abort = 1'($urandom_range(0, 1));
            else abort = 1'b0;
        end
    endtask

    initial begin
        int d, pd, ab;
        exp_t idle_e;

        //          row col   w    n    a  hold done  pd  ab
        vt[0]  = '{ 5, 33,  10,   2,   0, 1'b0,   37,   2, 0};
        vt[1]  = '{12,  7,   7,   0,   0, 1'b0,    9,   0, 0};
        vt[2]  = '{ 1,  2,   0,   3,   0, 1'b0,   24,   3, 0};
        vt[3]  = '{ 5, 33,  10,   2,   8, 1'b0,   13,   0, 1};
        vt[4]  = '{ 5, 33,  10,   2,   2, 1'b0,    7,   0, 1};
        vt[5]  = '{ 5, 33,  10,   2,  14, 1'b0,   19,   0, 1};
        vt[6]  = '{ 5, 33,  10,   2,  15, 1'b0,   20,   1, 1};
        vt[7]  = '{ 5, 33,  10,   2,  16, 1'b0,   21,   1, 1};
        vt[8]  = '{ 9, 40,  10,   2,   0, 1'b1,   37,   2, 0};
        vt[9]  = '{63, 63, 300,   1,   0, 1'b0,  313,   1, 0};
        vt[10] = '{ 0,  0,   1, 255,   0, 1'b0, 1284, 255, 0};

        idle_e       = '{default: 0};
        idle_e.ready = 1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_out(0, idle_e);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_cmd(vt[i].row, vt[i].col, vt[i].w, vt[i].n, vt[i].a, vt[i].hold, 1'b0, d, pd, ab);
            chk("tbl_done_cycle", i, d,  vt[i].exp_done);
            chk("tbl_pulses",     i, pd, vt[i].exp_pd);
            chk("tbl_aborted",    i, ab, vt[i].exp_ab);
        end

        // Reset during the second pulse of a W=10, N=2 command
        cmd_valid = 1'b1; cmd_row = 6'd5; cmd_col = 6'd33;
        cmd_pulse_width = 16'd10; cmd_num_pulses = 8'd2; abort = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("pre_rst_vinj",   20, vinj_pulse,  1);
        chk("pre_rst_pulses", 20, pulses_done, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_out(21, idle_e);
        rst = 1'b0;

        for (int r = 0; r < 30; r++) begin
            int row, col, w, n, a, we;
            bit hold;
            row  = $urandom_range(0, 63);
            col  = $urandom_range(0, 63);
            w    = $urandom_range(0, 12);
            n    = $urandom_range(0, 5);
            we   = (w == 0) ? 1 : w;
            a    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, S + n * (we + S)) : 0;
            hold = (r == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            run_cmd(row, col, w, n, a, hold, 1'b1, d, pd, ab);
            chk("rnd_aborted", r, ab, (a != 0) ? 1 : 0);
        end

        abort = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
